ttl_priority_interrupt_controller: RTL

Sequential 8-input priority interrupt controller built around 74148-style highest-index-wins encoding. It latches active-low request lines into a pending register and applies a loadable mask. It then runs an interrupt / acknowledge / end-of-interrupt handshake with a single consumer, presenting the winning line as an active-low 3-bit vector. It sits between discrete request sources and the CPU-side sequencer, replacing a 74148 plus 74175/74173 glue.

---
 rtl/ttl_priority_interrupt_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ttl_priority_interrupt_controller.sv
// ttl_priority_interrupt_controller
//
// Eight-line priority interrupt controller (74148-style, highest index wins)
// with a pending register, a loadable mask and an interrupt / acknowledge /
// end-of-interrupt handshake toward a single consumer.
//
// Optional feature macro: TTL_INTCTL_EDGE_TRIGGER_EN
//   undefined : level-sensitive request capture
//   defined   : falling-edge request capture via a request history register
//
// Ports
//   Clk           in   clock, all state changes on rising edge
//   Clear_bar     in   synchronous active-low reset
//   EI_bar        in   active-low enable, high blocks new interrupts
//   Req_bar       in   [WIDTH_IN]  active-low request lines, bit 7 highest
//   Mask          in   [WIDTH_IN]  mask value, 1 = masked
//   Load_Mask_bar in   active-low mask load strobe
//   Ack_bar       in   active-low interrupt acknowledge
//   EOI_bar       in   active-low end-of-interrupt
//   Int_bar       out  active-low interrupt request
//   Vector_bar    out  [WIDTH_OUT] inverted index of requested/serviced line
//   Pending       out  [WIDTH_IN]  pending register, active-high
//   InService     out  [WIDTH_IN]  one-hot in-service register
//
// FSM states
//   state      | meaning
//   ST_IDLE    | no interrupt outstanding, waiting for an eligible line
//   ST_ASSERT  | Int_bar low, vector frozen, waiting for Ack_bar
//   ST_SERVICE | line acknowledged and in service, waiting for EOI_bar

module ttl_priority_interrupt_controller #(
  parameter int WIDTH_IN   = 8,
  parameter int WIDTH_OUT  = 3,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                 Clk,
  input  logic                 Clear_bar,
  input  logic                 EI_bar,
  input  logic [WIDTH_IN-1:0]  Req_bar,
  input  logic [WIDTH_IN-1:0]  Mask,
  input  logic                 Load_Mask_bar,
  input  logic                 Ack_bar,
  input  logic                 EOI_bar,
  output logic                 Int_bar,
  output logic [WIDTH_OUT-1:0] Vector_bar,
  output logic [WIDTH_IN-1:0]  Pending,
  output logic [WIDTH_IN-1:0]  InService
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_int_bar;
  logic [WIDTH_OUT-1:0] r_vec_bar;
  logic [WIDTH_IN-1:0]  r_pend;
  logic [WIDTH_IN-1:0]  r_mask;
  logic [WIDTH_IN-1:0]  r_inserv;

  state_t               w_state_nxt;
  logic                 w_int_nxt;
  logic [WIDTH_OUT-1:0] w_vec_nxt;
  logic [WIDTH_IN-1:0]  w_pend_nxt;
  logic [WIDTH_IN-1:0]  w_mask_nxt;
  logic [WIDTH_IN-1:0]  w_inserv_nxt;
  logic [WIDTH_IN-1:0]  w_pend_clr;
  logic [WIDTH_IN-1:0]  w_req_set;

  logic [WIDTH_IN-1:0]  w_elig;
  logic                 w_any;
  logic [WIDTH_OUT-1:0] w_win;
  logic [WIDTH_OUT-1:0] w_cur_idx;
  logic [WIDTH_IN-1:0]  w_cur_oh;

  assign w_elig     = r_pend & ~r_mask;
  // The latched vector is the only record of which line is outstanding.
  assign w_cur_idx  = ~r_vec_bar;
  assign w_cur_oh   = WIDTH_IN'(1) << w_cur_idx;
  assign w_mask_nxt = Load_Mask_bar ? r_mask : Mask;

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = 0; i < WIDTH_IN; i++) begin
      if (w_elig[i]) begin
        w_any = 1'b1;
        w_win = WIDTH_OUT'(i);
      end
    end
  end

`ifdef TTL_INTCTL_EDGE_TRIGGER_EN
  logic [WIDTH_IN-1:0] r_req_hist;

  always_ff @(posedge Clk) begin
    if (!Clear_bar) r_req_hist <= '1;
    else            r_req_hist <= Req_bar;
  end

  // A fresh falling edge in the ack cycle beats the clear so it is not lost.
  assign w_req_set  = r_req_hist & ~Req_bar;
  assign w_pend_nxt = (r_pend & ~w_pend_clr) | w_req_set;
`else
  // Level capture: the ack clear wins; a still-low line re-sets next edge.
  assign w_req_set  = ~Req_bar;
  assign w_pend_nxt = (r_pend | w_req_set) & ~w_pend_clr;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_int_nxt    = r_int_bar;
    w_vec_nxt    = r_vec_bar;
    w_inserv_nxt = r_inserv;
    w_pend_clr   = '0;
    case (r_state)
      ST_IDLE: begin
        if (!EI_bar && w_any) begin
          w_state_nxt = ST_ASSERT;
          w_int_nxt   = 1'b0;
          w_vec_nxt   = ~w_win;
        end
      end
      ST_ASSERT: begin
        if (!Ack_bar) begin
          w_state_nxt  = ST_SERVICE;
          w_int_nxt    = 1'b1;
          w_pend_clr   = w_cur_oh;
          w_inserv_nxt = w_cur_oh;
        end else if (EI_bar || r_mask[w_cur_idx]) begin
          w_state_nxt = ST_IDLE;
          w_int_nxt   = 1'b1;
          w_vec_nxt   = '1;
        end
      end
      ST_SERVICE: begin
        if (!EOI_bar) begin
          w_state_nxt  = ST_IDLE;
          w_inserv_nxt = '0;
          w_vec_nxt    = '1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_int_nxt    = 1'b1;
        w_vec_nxt    = '1;
        w_inserv_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clear_bar) begin
      r_state   <= ST_IDLE;
      r_int_bar <= 1'b1;
      r_vec_bar <= '1;
      r_pend    <= '0;
      r_mask    <= '1;
      r_inserv  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_int_bar <= w_int_nxt;
      r_vec_bar <= w_vec_nxt;
      r_pend    <= w_pend_nxt;
      r_mask    <= w_mask_nxt;
      r_inserv  <= w_inserv_nxt;
    end
  end

  // Rise/fall delays belong to board-level timing annotation; the
  // synthesizable outputs are the registers themselves.
  if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_ext_output_delay
  end

  assign Int_bar    = r_int_bar;
  assign Vector_bar = r_vec_bar;
  assign Pending    = r_pend;
  assign InService  = r_inserv;

endmodule
